// File: rtl/flp_pkg.sv
// Shared floating-point datapath types and helpers: operand width, sign-magnitude
// payload, round-robin pointer rotation and a constant clog2.
package flp_pkg;

  localparam int unsigned FLP_IADD_W = 32;

  typedef struct packed {
    logic                  sn;
    logic [FLP_IADD_W-1:0] sg;
  } flp_sm_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Next candidate index after cur, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 32'd1 >= n) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/flp_iadd.sv
// Combinational sign-magnitude integer adder; sum is formed in WIDTH+2-bit two's
// complement and returned as sign, WIDTH+1-bit magnitude and a zero flag.
module flp_iadd
  import flp_pkg::*;
#(
  parameter int unsigned WIDTH = FLP_IADD_W
) (
  input  logic             i_sn1,
  input  logic [WIDTH-1:0] i_sg1,
  input  logic             i_sn2,
  input  logic [WIDTH-1:0] i_sg2,
  output logic             o_sn_c,
  output logic [WIDTH:0]   o_sg_c,
  output logic             o_zero_c
);

  localparam int unsigned SW = WIDTH + 2;
  localparam int unsigned MW = WIDTH + 1;

  logic [SW-1:0] a_c;
  logic [SW-1:0] b_c;
  logic [SW-1:0] s_c;

  always_comb begin
    a_c = {2'b00, i_sg1};
    b_c = {2'b00, i_sg2};
    if (i_sn1) a_c = ~a_c + SW'(1);
    if (i_sn2) b_c = ~b_c + SW'(1);
    s_c = a_c + b_c;
    // Two negative zeros keep the negative sign.
    o_sn_c   = s_c[SW-1] | (i_sn1 & i_sn2);
    o_sg_c   = MW'(s_c[SW-1] ? (~s_c + SW'(1)) : s_c);
    o_zero_c = (s_c == '0);
  end

endmodule

// File: rtl/flp_iadd_arb.sv
// Round-robin arbiter sharing one flp_iadd between NREQ requesters, with an operand
// stage and a registered result stage under full valid/ready backpressure.
module flp_iadd_arb
  import flp_pkg::*;
#(
  parameter int unsigned WIDTH = FLP_IADD_W,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         i_valid,
  output logic [NREQ-1:0]         o_ready,
  input  logic [NREQ-1:0]         i_sn1,
  input  logic [NREQ*WIDTH-1:0]   i_sg1,
  input  logic [NREQ-1:0]         i_sn2,
  input  logic [NREQ*WIDTH-1:0]   i_sg2,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [IDW-1:0]          o_id,
  output logic                    o_sn,
  output logic [WIDTH:0]          o_sg,
  output logic                    o_zero
);

  logic             s1_valid_q, s1_valid_d;
  logic [IDW-1:0]   s1_id_q,    s1_id_d;
  logic             s1_sn1_q,   s1_sn1_d;
  logic [WIDTH-1:0] s1_sg1_q,   s1_sg1_d;
  logic             s1_sn2_q,   s1_sn2_d;
  logic [WIDTH-1:0] s1_sg2_q,   s1_sg2_d;
  logic [IDW-1:0]   ptr_q,      ptr_d;
  logic             o_valid_q,  o_valid_d;
  logic [IDW-1:0]   o_id_q,     o_id_d;
  logic             o_sn_q,     o_sn_d;
  logic [WIDTH:0]   o_sg_q,     o_sg_d;
  logic             o_zero_q,   o_zero_d;

  logic             adv1_c, adv2_c, found_c, xfer_c;
  logic [IDW-1:0]   gnt_idx_c;
  logic [NREQ-1:0]  gnt_c;
  int unsigned      cand_c;
  logic             sum_sn_c, sum_zero_c;
  logic [WIDTH:0]   sum_sg_c;

  flp_iadd #(.WIDTH(WIDTH)) u_iadd (
    .i_sn1   (s1_sn1_q),
    .i_sg1   (s1_sg1_q),
    .i_sn2   (s1_sn2_q),
    .i_sg2   (s1_sg2_q),
    .o_sn_c  (sum_sn_c),
    .o_sg_c  (sum_sg_c),
    .o_zero_c(sum_zero_c)
  );

  // Stall chain and round-robin search starting just after the last grant.
  always_comb begin
    adv2_c    = ~o_valid_q | i_ready;
    adv1_c    = ~s1_valid_q | adv2_c;
    found_c   = 1'b0;
    gnt_idx_c = '0;
    gnt_c     = '0;
    cand_c    = 32'(ptr_q);
    for (int i = 0; i < int'(NREQ); i++) begin
      cand_c = rr_next(cand_c, NREQ);
      if (!found_c && i_valid[cand_c]) begin
        found_c   = 1'b1;
        gnt_idx_c = IDW'(cand_c);
      end
    end
    xfer_c = adv1_c & found_c;
    if (xfer_c) gnt_c[gnt_idx_c] = 1'b1;
  end

  assign o_ready = gnt_c;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_sn1_d   = s1_sn1_q;
    s1_sg1_d   = s1_sg1_q;
    s1_sn2_d   = s1_sn2_q;
    s1_sg2_d   = s1_sg2_q;
    ptr_d      = ptr_q;
    o_valid_d  = o_valid_q;
    o_id_d     = o_id_q;
    o_sn_d     = o_sn_q;
    o_sg_d     = o_sg_q;
    o_zero_d   = o_zero_q;
    if (adv1_c) begin
      s1_valid_d = xfer_c;
      if (xfer_c) begin
        ptr_d    = gnt_idx_c;
        s1_id_d  = gnt_idx_c;
        s1_sn1_d = i_sn1[gnt_idx_c];
        s1_sg1_d = i_sg1[32'(gnt_idx_c)*WIDTH +: WIDTH];
        s1_sn2_d = i_sn2[gnt_idx_c];
        s1_sg2_d = i_sg2[32'(gnt_idx_c)*WIDTH +: WIDTH];
      end
    end
    // Result registers only load real results so a drained output keeps its last value.
    if (adv2_c) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        o_id_d   = s1_id_q;
        o_sn_d   = sum_sn_c;
        o_sg_d   = sum_sg_c;
        o_zero_d = sum_zero_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_sn1_q   <= 1'b0;
      s1_sg1_q   <= '0;
      s1_sn2_q   <= 1'b0;
      s1_sg2_q   <= '0;
      ptr_q      <= IDW'(NREQ - 1);
      o_valid_q  <= 1'b0;
      o_id_q     <= '0;
      o_sn_q     <= 1'b0;
      o_sg_q     <= '0;
      o_zero_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_sn1_q   <= s1_sn1_d;
      s1_sg1_q   <= s1_sg1_d;
      s1_sn2_q   <= s1_sn2_d;
      s1_sg2_q   <= s1_sg2_d;
      ptr_q      <= ptr_d;
      o_valid_q  <= o_valid_d;
      o_id_q     <= o_id_d;
      o_sn_q     <= o_sn_d;
      o_sg_q     <= o_sg_d;
      o_zero_q   <= o_zero_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_id    = o_id_q;
  assign o_sn    = o_sn_q;
  assign o_sg    = o_sg_q;
  assign o_zero  = o_zero_q;

endmodule

// File: tb/tb_flp_iadd_arb.sv
// Directed bench for flp_iadd_arb at WIDTH=8, NREQ=4 with hand-computed expectations.
module tb_flp_iadd_arb;

  localparam int unsigned W   = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     i_valid;
  logic [N-1:0]     o_ready;
  logic [N-1:0]     i_sn1;
  logic [N*W-1:0]   i_sg1;
  logic [N-1:0]     i_sn2;
  logic [N*W-1:0]   i_sg2;
  logic             o_valid;
  logic             i_ready;
  logic [IDW-1:0]   o_id;
  logic             o_sn;
  logic [W:0]       o_sg;
  logic             o_zero;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  flp_iadd_arb #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_sn1  (i_sn1),
    .i_sg1  (i_sg1),
    .i_sn2  (i_sn2),
    .i_sg2  (i_sg2),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_id   (o_id),
    .o_sn   (o_sn),
    .o_sg   (o_sg),
    .o_zero (o_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    i_valid = '0;
    i_sn1   = '0;
    i_sg1   = '0;
    i_sn2   = '0;
    i_sg2   = '0;
  endtask

  task automatic set_req(input int k, input logic sn1, input logic [W-1:0] sg1,
                         input logic sn2, input logic [W-1:0] sg2);
    i_valid[k]       = 1'b1;
    i_sn1[k]         = sn1;
    i_sg1[k*W +: W]  = sg1;
    i_sn2[k]         = sn2;
    i_sg2[k*W +: W]  = sg2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_req();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated operation on an empty pipeline: grant, empty cycle, result.
  task automatic run_one(input string tag, input int k, input logic sn1, input logic [W-1:0] sg1,
                         input logic sn2, input logic [W-1:0] sg2,
                         input logic e_sn, input logic [W:0] e_sg, input logic e_zero);
    tick();
    clear_req();
    set_req(k, sn1, sg1, sn2, sg2);
    #1 check({tag, "_gnt"}, 32'(o_ready), 32'(1) << k);
    tick();
    clear_req();
    #1 check({tag, "_mid_valid"}, 32'(o_valid), 32'd0);
    tick();
    #1;
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_id"},    32'(o_id),    32'(k));
    check({tag, "_sn"},    32'(o_sn),    32'(e_sn));
    check({tag, "_sg"},    32'(o_sg),    32'(e_sg));
    check({tag, "_zero"},  32'(o_zero),  32'(e_zero));
  endtask

  int         gseq[6]   = '{0, 1, 2, 3, 0, 1};
  logic [3:0] t4_vld[9] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
  logic       t4_rdy[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0] t4_gnt[9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
  logic       t4_ov[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int         t4_id[9]  = '{0, 0, 0, 0, 0, 0, 1, 2, 0};
  logic [3:0] t5_vld[6] = '{4'b0010, 4'b1010, 4'b0010, 4'b0011, 4'b0000, 4'b0000};
  logic [3:0] t5_gnt[6] = '{4'b0010, 4'b1000, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
  int         t5_id[6]  = '{0, 0, 1, 3, 1, 0};

  initial begin
    i_ready = 1'b1;
    do_reset();
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_id",    32'(o_id),    32'd0);
    check("rst_sn",    32'(o_sn),    32'd0);
    check("rst_sg",    32'(o_sg),    32'd0);
    check("rst_zero",  32'(o_zero),  32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);

    // Single request and arithmetic corners.
    run_one("t1_p5m3",   0, 1'b0, 8'd5,   1'b1, 8'd3,   1'b0, 9'd2,   1'b0);
    run_one("t3_m5p5",   2, 1'b1, 8'd5,   1'b0, 8'd5,   1'b0, 9'd0,   1'b1);
    run_one("t3_m255x2", 1, 1'b1, 8'd255, 1'b1, 8'd255, 1'b1, 9'd510, 1'b0);
    run_one("t3_m0m0",   3, 1'b1, 8'd0,   1'b1, 8'd0,   1'b1, 9'd0,   1'b1);
    run_one("t3_m9p4",   0, 1'b1, 8'd9,   1'b0, 8'd4,   1'b1, 9'd5,   1'b0);

    // All four requesting: strict rotation from requester 0, no bubbles.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      tick();
      clear_req();
      if (c < 6)
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, 8'(k), 1'b0, 8'd10);
      #1;
      check("t2_gnt", 32'(o_ready), (c < 6) ? (32'(1) << gseq[c]) : 32'd0);
      if (c >= 2) begin
        check("t2_valid", 32'(o_valid), 32'd1);
        check("t2_id",    32'(o_id),    32'(gseq[c-2]));
        check("t2_sg",    32'(o_sg),    32'(gseq[c-2] + 10));
      end
    end

    // Backpressure with one extra grant, then in-order drain.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      tick();
      clear_req();
      for (int k = 0; k < 4; k++)
        if (t4_vld[c][k]) set_req(k, 1'b0, 8'(k + 1), 1'b0, 8'd0);
      i_ready = t4_rdy[c];
      #1;
      check("t4_gnt",   32'(o_ready), 32'(t4_gnt[c]));
      check("t4_valid", 32'(o_valid), 32'(t4_ov[c]));
      if (t4_ov[c]) begin
        check("t4_id", 32'(o_id), 32'(t4_id[c]));
        check("t4_sg", 32'(o_sg), 32'(t4_id[c] + 1));
      end
    end
    i_ready = 1'b1;

    // Round-robin fairness after a grant to requester 1.
    for (int c = 0; c < 6; c++) begin
      tick();
      clear_req();
      for (int k = 0; k < 4; k++)
        if (t5_vld[c][k]) set_req(k, 1'b0, 8'd1, 1'b0, 8'd1);
      #1;
      check("t5_gnt", 32'(o_ready), 32'(t5_gnt[c]));
      if (c >= 2) begin
        check("t5_valid", 32'(o_valid), 32'd1);
        check("t5_id",    32'(o_id),    32'(t5_id[c]));
      end
    end

    // Reset with both stages full: nothing delivered, pointer restarts at req0.
    tick();
    clear_req();
    i_ready = 1'b0;
    set_req(2, 1'b0, 8'd7, 1'b0, 8'd1);
    #1 check("t6_gnt_a", 32'(o_ready), 32'b0100);
    tick();
    clear_req();
    set_req(1, 1'b0, 8'd3, 1'b0, 8'd1);
    #1 check("t6_gnt_b", 32'(o_ready), 32'b0010);
    tick();
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, 8'd2, 1'b0, 8'd2);
    rst = 1'b1;
    #1;
    check("t6_full_valid", 32'(o_valid), 32'd1);
    check("t6_full_id",    32'(o_id),    32'd2);
    tick();
    rst = 1'b0;
    i_ready = 1'b1;
    #1;
    check("t6_post_valid", 32'(o_valid), 32'd0);
    check("t6_post_gnt",   32'(o_ready), 32'b0001);
    tick();
    clear_req();
    #1 check("t6_drop_valid", 32'(o_valid), 32'd0);
    tick();
    #1;
    check("t6_new_valid", 32'(o_valid), 32'd1);
    check("t6_new_id",    32'(o_id),    32'd0);
    check("t6_new_sg",    32'(o_sg),    32'd4);
    tick();
    #1 check("t6_idle_valid", 32'(o_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
